dense_layer_seq: RTL and testbench

Parametrised, time-multiplexed fully-connected layer: one multiply-accumulate per clock, with valid/ready handshakes on input and output. It supersedes the fixed-size combinational dense layers as the generic layer engine of the speech classifier pipeline. Each output neuron gets bias addition, optional ReLU, saturation and an argmax class index. It sits between the previous layer's output register and the next layer, or the final decision logic.

---
 rtl/dense_layer_seq.sv | 153 +++++++++++++++
 tb/tb_dense_layer_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_layer_seq.sv
// dense_layer_seq
//   Time-multiplexed fully-connected layer. One multiply-accumulate per clock;
//   each output neuron then gets bias, optional ReLU, saturation to OUT_W bits
//   and a running argmax. Valid/ready handshakes on both sides.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset
//   in_valid       input_vector valid
//   in_ready       block can accept a vector (high only in IDLE)
//   input_vector   IN_SIZE signed elements of IN_W bits, captured on accept
//   weights        weights[j][i], signed W_W bits, held static while busy
//   bias           bias[j], signed B_W bits, held static while busy
//   out_valid      output_vector / out_class valid
//   out_ready      consumer accepts the result
//   output_vector  OUT_SIZE signed saturated results of OUT_W bits
//   out_class      index of the largest output, ties to the lowest index
module dense_layer_seq #(
    parameter int IN_SIZE  = 32,
    parameter int OUT_SIZE = 3,
    parameter int IN_W     = 40,
    parameter int W_W      = 8,
    parameter int B_W      = 16,
    parameter int OUT_W    = 48,
    parameter int RELU     = 0,
    localparam int CLS_W   = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [IN_SIZE-1:0][IN_W-1:0]            input_vector,
    input  logic [OUT_SIZE-1:0][IN_SIZE-1:0][W_W-1:0] weights,
    input  logic [OUT_SIZE-1:0][B_W-1:0]            bias,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [OUT_SIZE-1:0][OUT_W-1:0]          output_vector,
    output logic [CLS_W-1:0]                        out_class
);

    // Full-precision accumulator: sum of IN_SIZE products never overflows.
    localparam int ACC_W  = IN_W + W_W + $clog2(IN_SIZE) + 1;
    localparam int PROD_W = IN_W + W_W;
    localparam int R_W    = ((ACC_W > B_W) ? ACC_W : B_W) + 1;
    localparam int EXT_W  = (R_W > OUT_W) ? R_W : OUT_W;
    localparam int I_W    = $clog2(IN_SIZE);
    localparam logic [I_W-1:0]   ELEM_LAST   = I_W'(IN_SIZE - 1);
    localparam logic [CLS_W-1:0] NEURON_LAST = CLS_W'(OUT_SIZE - 1);

    typedef enum logic [1:0] {IDLE, MAC, FINAL, DONE} state_t;

    state_t                          state;
    logic [I_W-1:0]                  elem_idx;
    logic [CLS_W-1:0]                neuron_idx;
    logic signed [ACC_W-1:0]         acc;
    logic [IN_SIZE-1:0][IN_W-1:0]    in_reg;
    logic signed [OUT_W-1:0]         best_val;
    logic [CLS_W-1:0]                best_idx;

    logic signed [PROD_W-1:0]        prod;
    logic signed [R_W-1:0]           biased;
    logic signed [OUT_W-1:0]         result;
    logic                            take;

    function automatic logic signed [R_W-1:0] relu(input logic signed [R_W-1:0] v);
        return (RELU != 0 && v < 0) ? '0 : v;
    endfunction

    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [R_W-1:0] v);
        logic signed [EXT_W-1:0] v_ext;
        logic signed [EXT_W-1:0] hi;
        logic signed [EXT_W-1:0] lo;
        v_ext = EXT_W'(v);
        hi    = $signed({{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
        lo    = $signed({{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}});
        if (v_ext > hi)      return hi[OUT_W-1:0];
        else if (v_ext < lo) return lo[OUT_W-1:0];
        else                 return v_ext[OUT_W-1:0];
    endfunction

    // MAC term and neuron finalisation datapath (combinational)
    always_comb begin
        prod   = PROD_W'($signed(in_reg[elem_idx])) * PROD_W'($signed(weights[neuron_idx][elem_idx]));
        biased = R_W'(acc) + R_W'($signed(bias[neuron_idx]));
        result = saturate(relu(biased));
        // Strict compare keeps the lowest index on ties; neuron 0 seeds the max.
        take   = (neuron_idx == '0) || (result > best_val);
    end

    // Control, accumulator and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            elem_idx      <= '0;
            neuron_idx    <= '0;
            acc           <= '0;
            best_idx      <= '0;
            in_ready      <= 1'b1;
            out_valid     <= 1'b0;
            output_vector <= '0;
            out_class     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state      <= MAC;
                        elem_idx   <= '0;
                        neuron_idx <= '0;
                        acc        <= '0;
                        in_ready   <= 1'b0;
                    end
                end
                MAC: begin
                    acc <= acc + ACC_W'(prod);
                    if (elem_idx == ELEM_LAST) begin
                        elem_idx <= '0;
                        state    <= FINAL;
                    end else begin
                        elem_idx <= elem_idx + I_W'(1);
                    end
                end
                FINAL: begin
                    output_vector[neuron_idx] <= result;
                    if (take) best_idx <= neuron_idx;
                    if (neuron_idx == NEURON_LAST) begin
                        out_class <= take ? neuron_idx : best_idx;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        neuron_idx <= neuron_idx + CLS_W'(1);
                        acc        <= '0;
                        state      <= MAC;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data-only registers: captured vector and running maximum value
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid && in_ready) in_reg <= input_vector;
        if (state == FINAL && take) best_val <= result;
    end

endmodule

// File: tb/tb_dense_layer_seq.sv
module tb_dense_layer_seq;

    localparam int N   = 4;
    localparam int M   = 3;
    localparam int LAT = M * (N + 1);

    logic clk;
    logic rst;
    logic in_valid;
    logic out_ready;
    logic [N-1:0][39:0]       input_vector;
    logic [M-1:0][N-1:0][7:0] weights;
    logic [M-1:0][15:0]       bias;

    logic rdy_a, vld_a, rdy_r, vld_r, rdy_s, vld_s;
    logic [M-1:0][47:0] out_a;
    logic [M-1:0][47:0] out_r;
    logic [M-1:0][7:0]  out_s;
    logic [1:0] cls_a, cls_r, cls_s;

    int tests = 0;
    int fails = 0;

    // Three configurations share the stimulus and run in lockstep.
    dense_layer_seq #(.IN_SIZE(N), .OUT_SIZE(M), .IN_W(40), .W_W(8), .B_W(16),
                      .OUT_W(48), .RELU(0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a),
        .input_vector(input_vector), .weights(weights), .bias(bias),
        .out_valid(vld_a), .out_ready(out_ready), .output_vector(out_a), .out_class(cls_a));

    dense_layer_seq #(.IN_SIZE(N), .OUT_SIZE(M), .IN_W(40), .W_W(8), .B_W(16),
                      .OUT_W(48), .RELU(1)) dut_r (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_r),
        .input_vector(input_vector), .weights(weights), .bias(bias),
        .out_valid(vld_r), .out_ready(out_ready), .output_vector(out_r), .out_class(cls_r));

    dense_layer_seq #(.IN_SIZE(N), .OUT_SIZE(M), .IN_W(40), .W_W(8), .B_W(16),
                      .OUT_W(8), .RELU(0)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s),
        .input_vector(input_vector), .weights(weights), .bias(bias),
        .out_valid(vld_s), .out_ready(out_ready), .output_vector(out_s), .out_class(cls_s));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0][39:0]       vin;
        logic [M-1:0][N-1:0][7:0] w;
        logic [M-1:0][15:0]       b;
        logic [M-1:0][47:0]       eo;
        logic [1:0]               ecls;
        logic [1:0]               sel;   // 0: RELU=0, 1: RELU=1, 2: OUT_W=8
    } vec_t;

    localparam int NV = 9;
    vec_t tbl [NV];

    function automatic longint get_out(input int sel, input int j);
        case (sel)
            0:       return longint'($signed(out_a[j]));
            1:       return longint'($signed(out_r[j]));
            default: return longint'($signed(out_s[j]));
        endcase
    endfunction

    function automatic int get_cls(input int sel);
        case (sel)
            0:       return int'(cls_a);
            1:       return int'(cls_r);
            default: return int'(cls_s);
        endcase
    endfunction

    function automatic logic get_vld(input int sel);
        case (sel)
            0:       return vld_a;
            1:       return vld_r;
            default: return vld_s;
        endcase
    endfunction

    task automatic check(input string name, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic set_in(input int k, input longint a0, input longint a1, input longint a2, input longint a3);
        tbl[k].vin[0] = 40'(a0); tbl[k].vin[1] = 40'(a1);
        tbl[k].vin[2] = 40'(a2); tbl[k].vin[3] = 40'(a3);
    endtask

    task automatic set_w(input int k, input int r, input int a0, input int a1, input int a2, input int a3);
        tbl[k].w[r][0] = 8'(a0); tbl[k].w[r][1] = 8'(a1);
        tbl[k].w[r][2] = 8'(a2); tbl[k].w[r][3] = 8'(a3);
    endtask

    task automatic set_b(input int k, input int b0, input int b1, input int b2);
        tbl[k].b[0] = 16'(b0); tbl[k].b[1] = 16'(b1); tbl[k].b[2] = 16'(b2);
    endtask

    task automatic set_exp(input int k, input longint e0, input longint e1, input longint e2,
                           input int cls, input int sel);
        tbl[k].eo[0] = 48'(e0); tbl[k].eo[1] = 48'(e1); tbl[k].eo[2] = 48'(e2);
        tbl[k].ecls  = 2'(cls);
        tbl[k].sel   = 2'(sel);
    endtask

    // Reference for the RELU=0, OUT_W=48 configuration.
    task automatic ref_model(input logic [N-1:0][39:0] vin, input logic [M-1:0][N-1:0][7:0] w,
                             input logic [M-1:0][15:0] b, output longint o [M], output int cls);
        longint s, best, hi, lo;
        hi   = (longint'(1) <<< 47) - 1;
        lo   = -(longint'(1) <<< 47);
        best = 0;
        cls  = 0;
        for (int j = 0; j < M; j++) begin
            s = longint'($signed(b[j]));
            for (int i = 0; i < N; i++)
                s += longint'($signed(vin[i])) * longint'($signed(w[j][i]));
            if (s > hi) s = hi;
            if (s < lo) s = lo;
            o[j] = s;
            if (j == 0 || s > best) begin
                best = s;
                cls  = j;
            end
        end
    endtask

    // Called #1 after a rising edge with the DUTs idle. Accepts the vector,
    // checks latency and results, and optionally completes the output handshake.
    task automatic run_entry(input vec_t e, input string tag, input bit ack);
        int lat;
        input_vector = e.vin;
        weights      = e.w;
        bias         = e.b;
        in_valid     = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (get_vld(int'(e.sel))) begin
                lat = c;
                break;
            end
        end
        check({tag, " latency"}, lat, LAT);
        for (int j = 0; j < M; j++)
            check($sformatf("%s out[%0d]", tag, j), get_out(int'(e.sel), j), longint'($signed(e.eo[j])));
        check({tag, " class"}, get_cls(int'(e.sel)), int'(e.ecls));
        if (ack) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
            check({tag, " out_valid after ack"}, vld_a, 0);
            check({tag, " in_ready after ack"}, rdy_a, 1);
        end
    endtask

    initial begin
        logic [M-1:0][47:0] snap;
        logic [N-1:0][39:0] va, vb;
        longint ro [M];
        int rc, gap, bad;

        // Vector table
        set_in(0, 1, 2, 3, 4);
        set_w(0, 0, 1, 1, 1, 1); set_w(0, 1, 2, 2, 2, 2); set_w(0, 2, -1, -1, -1, -1);
        set_b(0, 0, 5, 0);       set_exp(0, 10, 25, -10, 1, 0);
        tbl[1] = tbl[0]; set_b(1, 0, -5, 0); set_exp(1, 10, 15, 0, 1, 1);
        tbl[2] = tbl[0]; set_w(2, 1, 1, 1, 1, 1); set_w(2, 2, 1, 1, 1, 1);
        set_b(2, 0, 0, 0);       set_exp(2, 10, 10, 10, 0, 1);
        set_in(3, 100, 100, 100, 100);
        for (int r = 0; r < M; r++) set_w(3, r, 127, 127, 127, 127);
        set_b(3, 0, 0, 0);       set_exp(3, 127, 127, 127, 0, 2);
        tbl[4] = tbl[3];
        for (int r = 0; r < M; r++) set_w(4, r, -128, -128, -128, -128);
        set_exp(4, -128, -128, -128, 0, 2);
        set_in(5, -5, 7, 0, 3);
        set_w(5, 0, 1, 2, 3, 4); set_w(5, 1, -1, 0, 2, -3); set_w(5, 2, 3, 3, -2, 1);
        set_b(5, -1, 100, -9);   set_exp(5, 20, 96, 0, 1, 0);
        set_in(6, -(longint'(1) <<< 39), -(longint'(1) <<< 39), -(longint'(1) <<< 39), -(longint'(1) <<< 39));
        set_w(6, 0, -128, -128, -128, -128); set_w(6, 1, 127, 127, 127, 127); set_w(6, 2, 1, -1, 1, -1);
        set_b(6, 0, 0, -3);
        set_exp(6, (longint'(1) <<< 47) - 1, -(longint'(1) <<< 47), -3, 0, 0);
        tbl[7] = tbl[0];
        for (int r = 0; r < M; r++) set_w(7, r, -1, -1, -1, -1);
        set_b(7, 0, 0, 0);       set_exp(7, 0, 0, 0, 0, 1);
        tbl[8] = tbl[5]; set_in(8, 4, 3, 2, 1); set_exp(8, 19, 97, 9, 1, 0);

        // Reset state
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        input_vector = '0; weights = '0; bias = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", rdy_a, 1);
        check("reset out_valid", vld_a, 0);
        check("reset output_vector", (out_a == '0) ? 1 : 0, 1);
        check("reset out_class", cls_a, 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven vectors
        for (int k = 0; k < 8; k++)
            run_entry(tbl[k], $sformatf("vec%0d", k), 1'b1);

        // Backpressure: result held for 20 cycles, in_valid pulses ignored
        run_entry(tbl[0], "bp", 1'b0);
        snap = out_a;
        bad  = 0;
        for (int c = 0; c < 20; c++) begin
            in_valid     = c[0];
            input_vector = {N{40'(c + 77)}};
            @(posedge clk);
            #1;
            if (out_a !== snap || cls_a !== 2'd1 || rdy_a !== 1'b0 || vld_a !== 1'b1) bad++;
        end
        in_valid = 1'b0;
        check("bp stable cycles violated", bad, 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("bp out_valid after ack", vld_a, 0);
        check("bp in_ready after ack", rdy_a, 1);
        run_entry(tbl[8], "bp next", 1'b1);

        // Asynchronous reset seven cycles into a computation
        input_vector = tbl[5].vin; weights = tbl[5].w; bias = tbl[5].b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("async rst in_ready", rdy_a, 1);
        check("async rst out_valid", vld_a, 0);
        check("async rst output_vector", (out_a == '0) ? 1 : 0, 1);
        check("async rst out_class", cls_a, 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        run_entry(tbl[0], "post rst", 1'b1);

        // Back-to-back with in_valid and out_ready held high
        va = tbl[0].vin; vb = tbl[8].vin;
        weights = tbl[5].w; bias = tbl[5].b;
        input_vector = va;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 input_vector = vb;
        gap = -1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (vld_a) begin gap = c; break; end
        end
        check("b2b first latency", gap, LAT);
        ref_model(va, weights, bias, ro, rc);
        for (int j = 0; j < M; j++) check($sformatf("b2b A out[%0d]", j), get_out(0, j), ro[j]);
        check("b2b A class", cls_a, rc);
        gap = -1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (vld_a) begin gap = c; break; end
        end
        in_valid = 1'b0;
        // Latency plus the DONE handshake cycle plus the IDLE accept cycle.
        check("b2b spacing", gap, LAT + 2);
        ref_model(vb, weights, bias, ro, rc);
        for (int j = 0; j < M; j++) check($sformatf("b2b B out[%0d]", j), get_out(0, j), ro[j]);
        check("b2b B class", cls_a, rc);
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("b2b idle after", rdy_a, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
